// File: rtl/axi4_lite_master_bridge.sv
// AXI4-Lite master bridge: turns single-beat local requests into AXI4-Lite
// write/read transactions, one in flight, with response timeout and sticky error lock.
module axi4_lite_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              USR_ENA,
  input  logic [STRB_W-1:0] USR_WSTB,
  input  logic [ADDR_W-1:0] USR_ADDR,
  input  logic [DATA_W-1:0] USR_WDATA,
  output logic              USR_BUSY,
  output logic              USR_ACK,
  output logic [DATA_W-1:0] USR_RDATA,
  output logic [1:0]        USR_RESP,
  output logic              USR_TOERR,
  output logic [ADDR_W-1:0] AXI_AWADDR,
  output logic [2:0]        AXI_AWPROT,
  output logic              AXI_AWVALID,
  input  logic              AXI_AWREADY,
  output logic [DATA_W-1:0] AXI_WDATA,
  output logic [STRB_W-1:0] AXI_WSTRB,
  output logic              AXI_WVALID,
  input  logic              AXI_WREADY,
  input  logic [1:0]        AXI_BRESP,
  input  logic              AXI_BVALID,
  output logic              AXI_BREADY,
  output logic [ADDR_W-1:0] AXI_ARADDR,
  output logic [2:0]        AXI_ARPROT,
  output logic              AXI_ARVALID,
  input  logic              AXI_ARREADY,
  input  logic [DATA_W-1:0] AXI_RDATA,
  input  logic [1:0]        AXI_RRESP,
  input  logic              AXI_RVALID,
  output logic              AXI_RREADY
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0] RESP_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_ACK
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt;
  logic               timed_out;

  logic               awvalid_nxt, wvalid_nxt, arvalid_nxt;
  logic               bready_nxt, rready_nxt;
  logic               ack_nxt, busy_nxt, toerr_nxt;
  logic [ADDR_W-1:0]  awaddr_nxt, araddr_nxt;
  logic [DATA_W-1:0]  wdata_nxt, rdata_nxt;
  logic [STRB_W-1:0]  wstrb_nxt;
  logic [1:0]         resp_nxt;

  assign AXI_AWPROT = 3'b000;
  assign AXI_ARPROT = 3'b000;

  assign timed_out = (TIMEOUT != 0) && (wait_cnt == TO_LAST);

  // Response-wait counter: zero on the first cycle of WRESP/RDATA.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wait_cnt <= '0;
    end else if (state == S_WRESP || state == S_RDATA) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state       <= S_IDLE;
      AXI_AWVALID <= 1'b0;
      AXI_WVALID  <= 1'b0;
      AXI_ARVALID <= 1'b0;
      AXI_BREADY  <= 1'b0;
      AXI_RREADY  <= 1'b0;
      AXI_AWADDR  <= '0;
      AXI_WDATA   <= '0;
      AXI_WSTRB   <= '0;
      AXI_ARADDR  <= '0;
      USR_ACK     <= 1'b0;
      USR_BUSY    <= 1'b0;
      USR_TOERR   <= 1'b0;
      USR_RDATA   <= '0;
      USR_RESP    <= 2'b00;
    end else begin
      state       <= state_nxt;
      AXI_AWVALID <= awvalid_nxt;
      AXI_WVALID  <= wvalid_nxt;
      AXI_ARVALID <= arvalid_nxt;
      AXI_BREADY  <= bready_nxt;
      AXI_RREADY  <= rready_nxt;
      AXI_AWADDR  <= awaddr_nxt;
      AXI_WDATA   <= wdata_nxt;
      AXI_WSTRB   <= wstrb_nxt;
      AXI_ARADDR  <= araddr_nxt;
      USR_ACK     <= ack_nxt;
      USR_BUSY    <= busy_nxt;
      USR_TOERR   <= toerr_nxt;
      USR_RDATA   <= rdata_nxt;
      USR_RESP    <= resp_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    awvalid_nxt = AXI_AWVALID;
    wvalid_nxt  = AXI_WVALID;
    arvalid_nxt = AXI_ARVALID;
    awaddr_nxt  = AXI_AWADDR;
    wdata_nxt   = AXI_WDATA;
    wstrb_nxt   = AXI_WSTRB;
    araddr_nxt  = AXI_ARADDR;
    rdata_nxt   = USR_RDATA;
    resp_nxt    = USR_RESP;
    toerr_nxt   = USR_TOERR;

    case (state)
      S_IDLE: begin
        if (USR_ENA && !USR_TOERR) begin
          if (|USR_WSTB) begin
            state_nxt   = S_WADDR;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            awaddr_nxt  = USR_ADDR;
            wdata_nxt   = USR_WDATA;
            wstrb_nxt   = USR_WSTB;
          end else begin
            state_nxt   = S_RADDR;
            arvalid_nxt = 1'b1;
            araddr_nxt  = USR_ADDR;
          end
        end
      end

      // AW and W retire independently; move on once neither is pending.
      S_WADDR: begin
        awvalid_nxt = AXI_AWVALID & ~AXI_AWREADY;
        wvalid_nxt  = AXI_WVALID & ~AXI_WREADY;
        if (!awvalid_nxt && !wvalid_nxt) begin
          state_nxt = S_WRESP;
        end
      end

      S_WRESP: begin
        if (AXI_BVALID) begin
          resp_nxt  = AXI_BRESP;
          state_nxt = S_ACK;
        end else if (timed_out) begin
          resp_nxt  = RESP_TIMEOUT;
          toerr_nxt = 1'b1;
          state_nxt = S_ACK;
        end
      end

      S_RADDR: begin
        if (AXI_ARREADY) begin
          arvalid_nxt = 1'b0;
          state_nxt   = S_RDATA;
        end
      end

      // A timed-out read keeps the last good read data.
      S_RDATA: begin
        if (AXI_RVALID) begin
          rdata_nxt = AXI_RDATA;
          resp_nxt  = AXI_RRESP;
          state_nxt = S_ACK;
        end else if (timed_out) begin
          resp_nxt  = RESP_TIMEOUT;
          toerr_nxt = 1'b1;
          state_nxt = S_ACK;
        end
      end

      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Under error lock, IDLE keeps both response channels open to drain stragglers.
    bready_nxt = (state_nxt == S_WRESP) || (state_nxt == S_IDLE && toerr_nxt);
    rready_nxt = (state_nxt == S_RDATA) || (state_nxt == S_IDLE && toerr_nxt);
    ack_nxt    = (state_nxt == S_ACK);
    busy_nxt   = (state_nxt != S_IDLE) || toerr_nxt;
  end

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Directed bench for axi4_lite_master_bridge: vector table for 32-bit transactions
// plus hand sequences for error lock, asynchronous reset and the 64-bit variant.
module tb_axi4_lite_master_bridge;

  logic        aclk;
  logic        aresetn;

  logic        usr_ena;
  logic [3:0]  usr_wstb;
  logic [31:0] usr_addr, usr_wdata;
  logic        usr_busy, usr_ack, usr_toerr;
  logic [31:0] usr_rdata;
  logic [1:0]  usr_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  logic        d_ena;
  logic [7:0]  d_wstb, d_wstrb;
  logic [31:0] d_addr, d_awaddr, d_araddr;
  logic [63:0] d_wdata_in, d_rdata_out, d_wdata, d_rdata;
  logic        d_busy, d_ack, d_toerr;
  logic [1:0]  d_resp, d_bresp, d_rresp;
  logic [2:0]  d_awprot, d_arprot;
  logic        d_awvalid, d_awready, d_wvalid, d_wready, d_bvalid, d_bready;
  logic        d_arvalid, d_arready, d_rvalid, d_rready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    int          awc, wc, bc, arc, rc;
    logic [1:0]  sresp;
    logic [31:0] srdata;
    int          poke;
    int          exp_ack;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic        exp_toerr;
  } vec_t;

  vec_t vtab[8];

  axi4_lite_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u_dut32 (
    .ACLK(aclk), .ARESETn(aresetn),
    .USR_ENA(usr_ena), .USR_WSTB(usr_wstb), .USR_ADDR(usr_addr), .USR_WDATA(usr_wdata),
    .USR_BUSY(usr_busy), .USR_ACK(usr_ack), .USR_RDATA(usr_rdata), .USR_RESP(usr_resp),
    .USR_TOERR(usr_toerr),
    .AXI_AWADDR(awaddr), .AXI_AWPROT(awprot), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
    .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
    .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
    .AXI_ARADDR(araddr), .AXI_ARPROT(arprot), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
    .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready)
  );

  axi4_lite_master_bridge #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(256)) u_dut64 (
    .ACLK(aclk), .ARESETn(aresetn),
    .USR_ENA(d_ena), .USR_WSTB(d_wstb), .USR_ADDR(d_addr), .USR_WDATA(d_wdata_in),
    .USR_BUSY(d_busy), .USR_ACK(d_ack), .USR_RDATA(d_rdata_out), .USR_RESP(d_resp),
    .USR_TOERR(d_toerr),
    .AXI_AWADDR(d_awaddr), .AXI_AWPROT(d_awprot), .AXI_AWVALID(d_awvalid), .AXI_AWREADY(d_awready),
    .AXI_WDATA(d_wdata), .AXI_WSTRB(d_wstrb), .AXI_WVALID(d_wvalid), .AXI_WREADY(d_wready),
    .AXI_BRESP(d_bresp), .AXI_BVALID(d_bvalid), .AXI_BREADY(d_bready),
    .AXI_ARADDR(d_araddr), .AXI_ARPROT(d_arprot), .AXI_ARVALID(d_arvalid), .AXI_ARREADY(d_arready),
    .AXI_RDATA(d_rdata), .AXI_RRESP(d_rresp), .AXI_RVALID(d_rvalid), .AXI_RREADY(d_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_slave();
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid  = 1'b0; rvalid = 1'b0;
    bresp   = 2'b00; rresp = 2'b00; rdata = 32'h0;
  endtask

  // Cycle 0 presents the request; cycle c outputs are sampled and inputs for cycle c
  // driven at the falling edge inside cycle c.
  task automatic run_vec(input int idx, input vec_t v);
    bit aw_d, w_d, b_d, ar_d, r_d, proto_bad, cap_bad, post_bad;
    int ack_c;
    aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0;
    proto_bad = 0; cap_bad = 0; post_bad = 0; ack_c = -1;
    @(negedge aclk);
    usr_ena   = 1'b1;
    usr_wstb  = v.wr ? v.wstb : 4'h0;
    usr_addr  = v.addr;
    usr_wdata = v.wdata;
    for (int c = 1; c <= 40; c++) begin
      @(negedge aclk);
      usr_ena = (c == v.poke);
      if (usr_ack) begin
        ack_c = c;
        break;
      end
      if (awvalid !== (v.wr && !aw_d)) proto_bad = 1;
      if (wvalid  !== (v.wr && !w_d))  proto_bad = 1;
      if (arvalid !== (!v.wr && !ar_d)) proto_bad = 1;
      if (bready  !== (v.wr && aw_d && w_d && !b_d)) proto_bad = 1;
      if (rready  !== (!v.wr && ar_d && !r_d)) proto_bad = 1;
      if (usr_busy !== 1'b1) proto_bad = 1;
      if (awvalid && awaddr !== v.addr) cap_bad = 1;
      if (wvalid && (wdata !== v.wdata || wstrb !== v.wstb)) cap_bad = 1;
      if (arvalid && araddr !== v.addr) cap_bad = 1;
      awready = (c >= v.awc);
      wready  = (c >= v.wc);
      arready = (c >= v.arc);
      bvalid  = v.wr && aw_d && w_d && !b_d && (c >= v.bc);
      bresp   = v.sresp;
      rvalid  = !v.wr && ar_d && !r_d && (c >= v.rc);
      rresp   = v.sresp;
      rdata   = v.srdata;
      if (awvalid && awready) aw_d = 1;
      if (wvalid && wready)   w_d  = 1;
      if (arvalid && arready) ar_d = 1;
      if (bvalid && bready)   b_d  = 1;
      if (rvalid && rready)   r_d  = 1;
    end
    clear_slave();
    usr_ena = 1'b0;
    chk($sformatf("v%0d_ack_cycle", idx), 64'(ack_c), 64'(v.exp_ack));
    chk($sformatf("v%0d_resp", idx), 64'(usr_resp), 64'(v.exp_resp));
    chk($sformatf("v%0d_rdata", idx), 64'(usr_rdata), 64'(v.exp_rdata));
    chk($sformatf("v%0d_toerr", idx), 64'(usr_toerr), 64'(v.exp_toerr));
    chk($sformatf("v%0d_handshake_profile", idx), 64'(proto_bad), 64'(0));
    chk($sformatf("v%0d_bus_values", idx), 64'(cap_bad), 64'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      if (usr_ack || awvalid || wvalid || arvalid || (usr_busy !== v.exp_toerr)) post_bad = 1;
    end
    chk($sformatf("v%0d_after_ack", idx), 64'(post_bad), 64'(0));
  endtask

  initial begin
    bit lock_bad, drain_bad, rst_bad;
    int ack_c;

    aresetn = 1'b0;
    usr_ena = 1'b0; usr_wstb = 4'h0; usr_addr = 32'h0; usr_wdata = 32'h0;
    clear_slave();
    d_ena = 1'b0; d_wstb = 8'h00; d_addr = 32'h0; d_wdata_in = 64'h0;
    d_awready = 1'b1; d_wready = 1'b1; d_arready = 1'b1;
    d_bvalid = 1'b1; d_bresp = 2'b00; d_rvalid = 1'b1; d_rresp = 2'b00;
    d_rdata = 64'hFEDCBA98_76543210;

    //            wr    addr       wdata         wstb  awc wc bc arc rc  sresp  srdata        poke ack resp   exp_rdata     toerr
    vtab[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 1, 1, 2, 0, 0,  2'b00, 32'h0,        -1, 3,  2'b00, 32'h0,        1'b0};
    vtab[1] = '{1'b1, 32'h24,  32'hA5A50001, 4'h3, 1, 4, 5, 0, 0,  2'b10, 32'h0,        -1, 6,  2'b10, 32'h0,        1'b0};
    vtab[2] = '{1'b1, 32'h100, 32'h000000FF, 4'h1, 3, 1, 4, 0, 0,  2'b01, 32'h0,        -1, 5,  2'b01, 32'h0,        1'b0};
    vtab[3] = '{1'b0, 32'h40,  32'h0,        4'h0, 0, 0, 0, 1, 2,  2'b00, 32'hCAFEF00D, -1, 3,  2'b00, 32'hCAFEF00D, 1'b0};
    vtab[4] = '{1'b0, 32'h44,  32'h0,        4'h0, 0, 0, 0, 4, 6,  2'b00, 32'h12345678, -1, 7,  2'b00, 32'h12345678, 1'b0};
    vtab[5] = '{1'b1, 32'h8,   32'h11112222, 4'hC, 1, 1, 5, 0, 0,  2'b00, 32'h0,        3,  6,  2'b00, 32'h12345678, 1'b0};
    vtab[6] = '{1'b0, 32'h48,  32'h0,        4'h0, 0, 0, 0, 2, 3,  2'b10, 32'h0BADBAD0, -1, 4,  2'b10, 32'h0BADBAD0, 1'b0};
    vtab[7] = '{1'b0, 32'h4C,  32'h0,        4'h0, 0, 0, 0, 1, 99, 2'b00, 32'h55555555, -1, 10, 2'b10, 32'h0BADBAD0, 1'b1};

    @(negedge aclk);
    chk("reset_outputs", 64'(|{usr_busy, usr_ack, usr_rdata, usr_resp, usr_toerr, awaddr, awprot,
        awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready}), 64'(0));
    chk("reset_outputs_64", 64'(|{d_busy, d_ack, d_rdata_out, d_resp, d_toerr, d_awaddr, d_wdata,
        d_wstrb, d_awvalid, d_wvalid, d_bready, d_araddr, d_arvalid, d_rready}), 64'(0));
    aresetn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vtab[i]);

    // Error lock: requests refused, stale response drained without an acknowledge.
    @(negedge aclk);
    usr_ena = 1'b1; usr_wstb = 4'h0; usr_addr = 32'h50;
    lock_bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      usr_ena = 1'b0;
      if (arvalid || awvalid || usr_ack || !usr_busy) lock_bad = 1;
    end
    chk("lock_refuses_request", 64'(lock_bad), 64'(0));
    chk("lock_drain_ready", 64'({bready, rready}), 64'(2'b11));
    rvalid = 1'b1; rdata = 32'hFFFF0000; rresp = 2'b00;
    @(negedge aclk);
    rvalid = 1'b0;
    drain_bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      if (usr_ack) drain_bad = 1;
    end
    chk("lock_drain_no_ack", 64'(drain_bad), 64'(0));
    chk("lock_rdata_kept", 64'(usr_rdata), 64'(32'h0BADBAD0));
    chk("lock_sticky", 64'({usr_toerr, usr_busy}), 64'(2'b11));

    // Reset clears the lock; then reset again in the middle of WADDR.
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    chk("reset_clears_lock", 64'({usr_toerr, usr_busy}), 64'(2'b00));
    @(negedge aclk);
    usr_ena = 1'b1; usr_wstb = 4'hF; usr_addr = 32'h60; usr_wdata = 32'h01020304;
    @(negedge aclk);
    usr_ena = 1'b0;
    @(negedge aclk);
    chk("midwaddr_valids_before", 64'({awvalid, wvalid, usr_busy}), 64'(3'b111));
    aresetn = 1'b0;
    #1;
    chk("midwaddr_async_drop", 64'({awvalid, wvalid, usr_busy, bready}), 64'(4'b0000));
    @(negedge aclk);
    aresetn = 1'b1;
    rst_bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      if (usr_ack || awvalid || wvalid || usr_busy) rst_bad = 1;
    end
    chk("midwaddr_back_to_idle", 64'(rst_bad), 64'(0));
    run_vec(8, vtab[0]);

    // 64-bit instance with an always-ready slave.
    @(negedge aclk);
    d_ena = 1'b1; d_wstb = 8'h0F; d_addr = 32'h80; d_wdata_in = 64'h01234567_89ABCDEF;
    @(negedge aclk);
    d_ena = 1'b0;
    chk("w64_wstrb", 64'(d_wstrb), 64'(8'h0F));
    chk("w64_wdata", d_wdata, 64'h01234567_89ABCDEF);
    chk("w64_valids", 64'({d_awvalid, d_wvalid}), 64'(2'b11));
    ack_c = -1;
    for (int c = 2; c <= 20; c++) begin
      @(negedge aclk);
      if (d_ack) begin ack_c = c; break; end
    end
    chk("w64_ack_cycle", 64'(ack_c), 64'(3));
    @(negedge aclk);
    d_ena = 1'b1; d_wstb = 8'h00; d_addr = 32'h88;
    @(negedge aclk);
    d_ena = 1'b0;
    chk("r64_araddr", 64'({d_arvalid, d_araddr}), {31'h0, 1'b1, 32'h88});
    ack_c = -1;
    for (int c = 2; c <= 20; c++) begin
      @(negedge aclk);
      if (d_ack) begin ack_c = c; break; end
    end
    chk("r64_ack_cycle", 64'(ack_c), 64'(3));
    chk("r64_rdata", d_rdata_out, 64'hFEDCBA98_76543210);
    chk("r64_resp", 64'(d_resp), 64'(2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
